// File: rtl/fft_bit_reverse_buffer_pkg.sv
// Shared definitions for the FFT output reorder stage: read FSM states and
// the constant log2 helper used by the FFT blocks to size counters.
package fft_bit_reverse_buffer_pkg;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Smallest r with 2**r >= value; evaluated at elaboration time.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM for the reorder ping-pong buffer: one write port and
// one registered read port, no reset on storage or read data.
module fft_reorder_ram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bit_reverse_buffer.sv
// Restores natural bin order after the SDF FFT: each frame is written to one
// bank at bit-reversed addresses while the other bank is read out linearly.
module fft_bit_reverse_buffer
    import fft_bit_reverse_buffer_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i,
    output logic             frame_drop
);

    localparam int LOG_N = log2_ceil(N);
    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
        logic [LOG_N-1:0] r;
        for (int b = 0; b < LOG_N; b++) begin
            r[b] = v[LOG_N-1-b];
        end
        return r;
    endfunction

    // Write side state
    logic [LOG_N-1:0] wcount_reg, wcount_next;
    logic             wbank_reg, wbank_next;
    logic             wbad_reg, wbad_next;
    logic [1:0]       full_reg, full_next;
    logic             frame_drop_reg;

    // Read side state
    rd_state_t        state_reg, state_next;
    logic             rbank_reg, rbank_next;
    logic [LOG_N-1:0] rcount_reg, rcount_next;
    logic             odata_en_reg;

    logic             wr_block, wr_en, frame_done, full_set, drop_now, full_clr;
    logic [1:0]       full_new, full_avail;
    logic [2*WIDTH-1:0] rd_data;

    // A frame that ever touched a still-full bank is poisoned until it ends.
    assign wr_block   = full_reg[wbank_reg] | wbad_reg;
    assign wr_en      = idata_en & ~wr_block;
    assign frame_done = idata_en & (wcount_reg == LAST_IDX);
    assign full_set   = frame_done & ~wr_block;
    assign drop_now   = (~idata_en & (wcount_reg != '0)) | (frame_done & wr_block);
    assign full_new   = {full_set & wbank_reg, full_set & ~wbank_reg};
    assign full_avail = full_reg | full_new;

    always_comb begin
        wcount_next = '0;
        wbank_next  = wbank_reg;
        wbad_next   = wbad_reg;
        if (idata_en) begin
            wcount_next = wcount_reg + 1'b1;
        end
        if (frame_done || !idata_en) begin
            wbad_next = 1'b0;
        end else if (full_reg[wbank_reg]) begin
            wbad_next = 1'b1;
        end
        if (full_set) begin
            wbank_next = ~wbank_reg;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rbank_next  = rbank_reg;
        rcount_next = rcount_reg;
        full_clr    = 1'b0;
        case (state_reg)
            RD_IDLE: begin
                if (full_avail != 2'b00) begin
                    state_next  = RD_READ;
                    rcount_next = '0;
                    // With both banks full the oldest is the one not just completed.
                    if (full_avail == 2'b11) begin
                        rbank_next = full_set ? ~wbank_reg : wbank_reg;
                    end else begin
                        rbank_next = full_avail[1];
                    end
                end
            end
            RD_READ: begin
                rcount_next = rcount_reg + 1'b1;
                if (rcount_reg == LAST_IDX) begin
                    full_clr = 1'b1;
                    if (full_avail[~rbank_reg]) begin
                        rbank_next = ~rbank_reg;
                    end else begin
                        state_next = RD_IDLE;
                    end
                end
            end
            default: state_next = RD_IDLE;
        endcase
        full_next = (full_reg & ~{full_clr & rbank_reg, full_clr & ~rbank_reg}) | full_new;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcount_reg     <= '0;
            wbank_reg      <= 1'b0;
            wbad_reg       <= 1'b0;
            full_reg       <= 2'b00;
            frame_drop_reg <= 1'b0;
            state_reg      <= RD_IDLE;
            rbank_reg      <= 1'b0;
            rcount_reg     <= '0;
            odata_en_reg   <= 1'b0;
        end else begin
            wcount_reg     <= wcount_next;
            wbank_reg      <= wbank_next;
            wbad_reg       <= wbad_next;
            full_reg       <= full_next;
            frame_drop_reg <= drop_now;
            state_reg      <= state_next;
            rbank_reg      <= rbank_next;
            rcount_reg     <= rcount_next;
            odata_en_reg   <= (state_reg == RD_READ);
        end
    end

    fft_reorder_ram #(
        .ADDR_W (LOG_N + 1),
        .DATA_W (2 * WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr ({wbank_reg, bitrev(wcount_reg)}),
        .wr_data ({idata_r, idata_i}),
        .rd_en   (state_reg == RD_READ),
        .rd_addr ({rbank_reg, rcount_reg}),
        .rd_data (rd_data)
    );

    // RAM read register is the output stage; gating keeps data at zero when idle.
    assign odata_en   = odata_en_reg;
    assign odata_r    = odata_en_reg ? rd_data[2*WIDTH-1:WIDTH] : '0;
    assign odata_i    = odata_en_reg ? rd_data[WIDTH-1:0] : '0;
    assign frame_drop = frame_drop_reg;

endmodule
